timer_tick_master: RTL
======================

TIMER_TICK_MASTER -- requirements
Module: timer_tick_master

Interface
REQ-001 SHALL have parameter PERIOD, default 32'd49999, meaning the 32-bit load value written to the interval timer (period = PERIOD+1 clk cycles).
REQ-002 SHALL have parameter CONTINUOUS, default 1, meaning 1 = periodic timer, 0 = one-shot.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1, level request to run the timer.
REQ-006 SHALL have port irq, input, 1, interrupt from the interval timer.
REQ-007 SHALL have port av_address, output, 3, interval timer register address.
REQ-008 SHALL have port av_chipselect, output, 1, timer chipselect.
REQ-009 SHALL have port av_write_n, output, 1, active-low timer write.
REQ-010 SHALL have port av_writedata, output, 16, timer write data.
REQ-011 SHALL have port tick_valid, output, 1, a tick is pending for the consumer.
REQ-012 SHALL have port tick_ready, input, 1, consumer accepts the pending tick.
REQ-013 SHALL have port tick_count, output, 16, number of ticks serviced.
REQ-014 SHALL have port running, output, 1, high in RUN, CLR and WAIT states.
REQ-015 SHALL have port overrun_count, output, 8, ticks raised while a tick was still pending.

Function
REQ-016 SHALL implement states IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR, WAIT, STOP.
REQ-017 SHALL decode av_* from the state register only; no combinational input-to-output path.
REQ-018 SHALL drive chipselect=1, write_n=0 only in WR_PL, WR_PH, WR_CTL, CLR, STOP; otherwise chipselect=0, write_n=1, address=0, writedata=0.
REQ-019 SHALL write in WR_PL address 2, data PERIOD[15:0]; in WR_PH address 3, data PERIOD[31:16].
REQ-020 SHALL write in WR_CTL address 1, data 0x0007 when CONTINUOUS=1, 0x0005 when CONTINUOUS=0.
REQ-021 SHALL write in CLR address 0, data 0x0000; in STOP address 1, data 0x0008.
REQ-022 SHALL leave IDLE for WR_PL on enable=1 (CONTINUOUS=1) or on an enable rising edge (CONTINUOUS=0).
REQ-023 SHALL step WR_PL->WR_PH->WR_CTL->RUN, one cycle each, regardless of irq or enable.
REQ-024 SHALL go RUN->CLR on irq=1, else RUN->STOP on enable=0; irq takes priority when both occur.
REQ-025 SHALL go CLR->WAIT unconditionally; WAIT lasts exactly one cycle and ignores irq.
REQ-026 SHALL go WAIT->RUN when CONTINUOUS=1, WAIT->IDLE when CONTINUOUS=0.
REQ-027 SHALL go STOP->IDLE unconditionally.
REQ-028 SHALL raise a tick event on each cycle in CLR.
REQ-029 SHALL increment tick_count by 1 on each tick event, wrapping 0xFFFF->0x0000.
REQ-030 SHALL set tick_valid on a tick event and clear it on tick_valid&tick_ready; a simultaneous tick event and accept leaves tick_valid=1.
REQ-031 SHALL take the enable edge from a register of enable sampled every cycle.

Reset
REQ-032 SHALL, while reset=1, set state IDLE, tick_valid=0, tick_count=0, overrun_count=0, running=0, enable history=0, and av_* to their idle values.
REQ-033 SHALL abandon any state on reset with no STOP write issued; the timer has its own reset.

Configuration
REQ-034 SHALL, with TICK_OVERRUN_EN defined, increment overrun_count on a tick event while tick_valid=1 and tick_ready=0, saturating at 0xFF.
REQ-035 SHALL, without TICK_OVERRUN_EN, keep the overrun_count port and drive it constant 0x00.

Verification
REQ-036 SHALL cover: PERIOD=9, CONTINUOUS=1, enable=1 after reset -> writes (2,0x0009),(3,0x0000),(1,0x0007) on three consecutive cycles, then RUN.
REQ-037 SHALL cover: pulse irq high in RUN -> one write (0,0x0000), tick_count 0->1, tick_valid=1 until tick_ready, then return to RUN after WAIT.
REQ-038 SHALL cover: irq and enable=0 in the same RUN cycle -> CLR, WAIT, then STOP write (1,0x0008), then IDLE, tick_count=1.
REQ-039 SHALL cover: CONTINUOUS=0, enable held high -> one programming burst with ctl 0x0005; after the tick the FSM stays in IDLE until enable goes 0->1.
REQ-040 SHALL cover: TICK_OVERRUN_EN defined, tick_ready=0, 300 ticks -> overrun_count=0xFF and tick_count=300; without the macro -> overrun_count=0x00.
REQ-041 SHALL cover: reset asserted in WR_PH -> next cycle IDLE with no further timer writes, all outputs at reset values.

Source files
------------

// File: rtl/timer_tick_master.sv
// Sequencer for an interval timer: programs period and control, turns each timer irq into a
// ready/valid tick with a running count. Define TICK_OVERRUN_EN to count ticks raised while one is still pending.
`timescale 1ns/1ps
module timer_tick_master #(
  parameter logic [31:0] PERIOD     = 32'd49999,
  parameter bit          CONTINUOUS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        irq,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  output logic        tick_valid,
  input  logic        tick_ready,
  output logic [15:0] tick_count,
  output logic        running,
  output logic [7:0]  overrun_count
);

  // state  | meaning
  // IDLE   | timer stopped, waiting for an enable request
  // WR_PL  | write low half of the period
  // WR_PH  | write high half of the period
  // WR_CTL | write control: start, irq enable, continuous or one-shot
  // RUN    | timer counting, waiting for irq or enable drop
  // CLR    | clear the timer status (acknowledges irq), raises a tick
  // WAIT   | one-cycle guard so the clearing write settles before irq is looked at again
  // STOP   | write control stop bit
  typedef enum logic [2:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR, WAIT, STOP
  } state_t;

  localparam logic [15:0] CTL_START = CONTINUOUS ? 16'h0007 : 16'h0005;
  localparam logic [15:0] CTL_STOP  = 16'h0008;

  state_t      state_q, state_d;
  logic        enable_q;
  logic        tick_valid_q, tick_valid_d;
  logic [15:0] tick_count_q, tick_count_d;
  logic        tick_event;
  logic        start_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      tick_valid_q <= 1'b0;
      tick_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable;
      tick_valid_q <= tick_valid_d;
      tick_count_q <= tick_count_d;
    end
  end

  // One-shot mode needs a fresh request after each expiry, so it restarts only on a rising edge.
  assign start_req = CONTINUOUS ? enable : (enable & ~enable_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_req) state_d = WR_PL;
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTL;
      WR_CTL:  state_d = RUN;
      RUN: begin
        if (irq)          state_d = CLR;
        else if (!enable) state_d = STOP;
      end
      CLR:     state_d = WAIT;
      WAIT:    state_d = CONTINUOUS ? RUN : IDLE;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = 3'd0;
    av_writedata  = 16'h0000;
    case (state_q)
      WR_PL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd2;
        av_writedata  = PERIOD[15:0];
      end
      WR_PH: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd3;
        av_writedata  = PERIOD[31:16];
      end
      WR_CTL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd1;
        av_writedata  = CTL_START;
      end
      CLR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd0;
        av_writedata  = 16'h0000;
      end
      STOP: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = 3'd1;
        av_writedata  = CTL_STOP;
      end
      default: ;
    endcase
  end

  assign tick_event = (state_q == CLR);
  assign running    = (state_q == RUN) || (state_q == CLR) || (state_q == WAIT);

  // A new tick wins over a same-cycle accept: the consumer took the old one, the new one is pending.
  always_comb begin
    tick_valid_d = tick_valid_q;
    tick_count_d = tick_count_q;
    if (tick_event) begin
      tick_valid_d = 1'b1;
      tick_count_d = tick_count_q + 16'd1;
    end else if (tick_valid_q && tick_ready) begin
      tick_valid_d = 1'b0;
    end
  end

  assign tick_valid = tick_valid_q;
  assign tick_count = tick_count_q;

`ifdef TICK_OVERRUN_EN
  logic [7:0] overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 8'h00;
    else       overrun_q <= overrun_d;
  end

  always_comb begin
    overrun_d = overrun_q;
    if (tick_event && tick_valid_q && !tick_ready && (overrun_q != 8'hFF))
      overrun_d = overrun_q + 8'd1;
  end

  assign overrun_count = overrun_q;
`else
  assign overrun_count = 8'h00;
`endif

endmodule
